restoring_divider_seq: RTL and testbench

//  Multi-cycle restoring divider for the KGP-RISC ALU: the inverse datapath to
//  the 32-bit carry-lookahead adder. Computes quotient and remainder by repeated

---
 rtl/restoring_divider_seq.sv | 167 ++++++++++++++++
 tb/tb_restoring_divider_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_seq.sv
//==============================================================================
// Module  : restoring_divider_seq
// Brief   : Multi-cycle restoring divider, one quotient bit per clock, with a
//           valid/ready handshake. Signed mode is built with DIVIDER_SIGNED_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_divider_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             signed_op_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] res_quo_q, res_quo_d;
   logic [WIDTH-1:0] res_rem_q, res_rem_d;
   logic             dbz_q, dbz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] rem_shift, rem_next, quo_next;
   logic [WIDTH-1:0] fin_quo, fin_rem;
   logic [WIDTH:0]   trial;

   // One restoring step: shift in the next dividend bit, keep the difference if it is non-negative
   assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign trial     = {1'b0, rem_shift} - {1'b0, div_q};
   assign rem_next  = trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
   assign quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIVIDER_SIGNED_EN
   logic a_neg, b_neg;
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   assign a_neg   = signed_op_i & dividend_i[WIDTH-1];
   assign b_neg   = signed_op_i & divisor_i[WIDTH-1];
   assign a_mag   = a_neg ? -dividend_i : dividend_i;
   assign b_mag   = b_neg ? -divisor_i  : divisor_i;
   // MIN/-1 needs no special case: |MIN| divides to MIN and the signs cancel
   assign fin_quo = neg_quo_q ? -quo_next : quo_next;
   assign fin_rem = neg_rem_q ? -rem_next : rem_next;
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op_i;
   assign a_mag   = dividend_i;
   assign b_mag   = divisor_i;
   assign fin_quo = quo_next;
   assign fin_rem = rem_next;
`endif

   always_comb begin
      state_d   = state_q;
      quo_d     = quo_q;
      div_d     = div_q;
      rem_d     = rem_q;
      res_quo_d = res_quo_q;
      res_rem_d = res_rem_q;
      dbz_d     = dbz_q;
      cnt_d     = cnt_q;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               if (divisor_i == '0) begin
                  res_quo_d = '1;
                  res_rem_d = dividend_i;
                  dbz_d     = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  quo_d   = a_mag;
                  div_d   = b_mag;
                  rem_d   = '0;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
`endif
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d = rem_next;
            quo_d = quo_next;
            if (cnt_q == '0) begin
               res_quo_d = fin_quo;
               res_rem_d = fin_rem;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         quo_q     <= '0;
         div_q     <= '0;
         rem_q     <= '0;
         res_quo_q <= '0;
         res_rem_q <= '0;
         dbz_q     <= 1'b0;
         cnt_q     <= '0;
`ifdef DIVIDER_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         res_quo_q <= res_quo_d;
         res_rem_q <= res_rem_d;
         dbz_q     <= dbz_d;
         cnt_q     <= cnt_d;
`ifdef DIVIDER_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign in_ready_o    = (state_q == S_IDLE);
   assign out_valid_o   = (state_q == S_DONE);
   assign quotient_o    = res_quo_q;
   assign remainder_o   = res_rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_seq.sv
//==============================================================================
// Module  : tb_restoring_divider_seq
// Brief   : Directed plus random operations for restoring_divider_seq.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_restoring_divider_seq;

   localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         signed_op = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   restoring_divider_seq #(.WIDTH(W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .signed_op_i  (signed_op),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .quotient_o   (quotient),
      .remainder_o  (remainder),
      .div_by_zero_o(div_by_zero)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic straight from the division rules, not from the datapath
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      logic signed [W-1:0] sa, sb;
      sa = a;
      sb = b;
      z  = 1'b0;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (SIGNED_BUILD && s) begin
         if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
      logic [W-1:0] eq, er;
      logic         ez;
      int           edges;
      model(a, b, s, eq, er, ez);
      check("ready_before_op", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      signed_op = s;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom_range(0, 1));
      edges = 1;
      while (!out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      check("latency", edges, (b == '0) ? 32'd1 : 32'(W + 1));
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
      check("ready_in_done", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         dividend = $urandom;
         divisor  = $urandom;
         @(posedge clk); #1;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_ready", {31'd0, in_ready}, 32'd0);
         check("hold_quotient", quotient, eq);
         check("hold_remainder", remainder, er);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("taken_valid", {31'd0, out_valid}, 32'd0);
      check("taken_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] a, b;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op(32'd5, 32'd9, 1'b0, 0);
      run_op(32'd1234, 32'd0, 1'b0, 10);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'd42, 32'd42, 1'b0, 10);

      // Abort an operation in flight, then confirm a clean restart
      in_valid = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
      run_op(32'd100, 32'd7, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
